// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard for tracking writes that are still pending.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Wenable,
  input  logic [ADDR_W-1:0] WrtAddress,
  input  logic [WIDTH-1:0]  DataIn,
  input  logic [ADDR_W-1:0] RdAddress1,
  input  logic [ADDR_W-1:0] RdAddress2,
  output logic [WIDTH-1:0]  DataA,
  output logic [WIDTH-1:0]  DataB,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ResAddress,
  output logic              Busy1,
  output logic              Busy2,
  output logic              AnyBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wrMasked;
  logic resMasked;
  logic rd1Masked;
  logic rd2Masked;
  logic fwd1;
  logic fwd2;

  assign wrMasked  = (ZERO_REG != 0) && (WrtAddress == '0);
  assign resMasked = (ZERO_REG != 0) && (ResAddress == '0);
  assign rd1Masked = (ZERO_REG != 0) && (RdAddress1 == '0);
  assign rd2Masked = (ZERO_REG != 0) && (RdAddress2 == '0);

  // Forwarding is gated by reset so a write strobe held during reset
  // cannot leak DataIn onto the read ports.
  assign fwd1 = (BYPASS != 0) && Reset && Wenable && !wrMasked && (WrtAddress == RdAddress1);
  assign fwd2 = (BYPASS != 0) && Reset && Wenable && !wrMasked && (WrtAddress == RdAddress2);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (Wenable && !wrMasked) begin
      regs[WrtAddress] <= DataIn;
    end
  end

  // The reserve assignment comes last so it wins over a same-address write.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      busy <= '0;
    end else begin
      if (Wenable && !wrMasked) begin
        busy[WrtAddress] <= 1'b0;
      end
      if (Reserve && !resMasked) begin
        busy[ResAddress] <= 1'b1;
      end
    end
  end

  always_comb begin
    DataA = '0;
    DataB = '0;
    if (!rd1Masked) begin
      DataA = fwd1 ? DataIn : regs[RdAddress1];
    end
    if (!rd2Masked) begin
      DataB = fwd2 ? DataIn : regs[RdAddress2];
    end
  end

  assign Busy1   = busy[RdAddress1] && !fwd1 && !rd1Masked;
  assign Busy2   = busy[RdAddress2] && !fwd2 && !rd2Masked;
  assign AnyBusy = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance and a BYPASS=0 / ZERO_REG=0 instance
// share one stimulus stream and are compared against an array-based reference model.
module tb_reg_file_sb;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic clk = 1'b0;
  logic rstn;
  logic we;
  logic res;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] rsa;
  logic [W-1:0] din;

  logic [1:0][W-1:0] dataA;
  logic [1:0][W-1:0] dataB;
  logic [1:0] busy1;
  logic [1:0] busy2;
  logic [1:0] anyBusy;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  bit cfgZero [2] = '{1'b1, 1'b0};
  bit cfgByp  [2] = '{1'b1, 1'b0};
  logic [W-1:0] mRegs [2][D];
  bit mBusy [2][D];

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dutDef (
    .clk(clk), .Reset(rstn), .Wenable(we), .WrtAddress(wa), .DataIn(din),
    .RdAddress1(ra1), .RdAddress2(ra2), .DataA(dataA[0]), .DataB(dataB[0]),
    .Reserve(res), .ResAddress(rsa), .Busy1(busy1[0]), .Busy2(busy2[0]),
    .AnyBusy(anyBusy[0])
  );

  reg_file_sb #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dutAlt (
    .clk(clk), .Reset(rstn), .Wenable(we), .WrtAddress(wa), .DataIn(din),
    .RdAddress1(ra1), .RdAddress2(ra2), .DataA(dataA[1]), .DataB(dataB[1]),
    .Reserve(res), .ResAddress(rsa), .Busy1(busy1[1]), .Busy2(busy2[1]),
    .AnyBusy(anyBusy[1])
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < D; i++) begin
        mRegs[c][i] = '0;
        mBusy[c][i] = 1'b0;
      end
    end
  endtask

  function automatic logic [W-1:0] expData(int c, logic [AW-1:0] a);
    if (!rstn) return '0;
    if (cfgZero[c] && a == 0) return '0;
    if (cfgByp[c] && we && a == wa) return din;
    return mRegs[c][a];
  endfunction

  function automatic logic expBusy(int c, logic [AW-1:0] a);
    if (!rstn) return 1'b0;
    if (cfgZero[c] && a == 0) return 1'b0;
    if (cfgByp[c] && we && a == wa) return 1'b0;
    return mBusy[c][a];
  endfunction

  function automatic logic expAny(int c);
    logic any = 1'b0;
    for (int i = 0; i < D; i++) any |= mBusy[c][i];
    return any;
  endfunction

  task automatic checkOutput();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("cfg%0d_DataA_r%0d", c, ra1), dataA[c], expData(c, ra1));
      check($sformatf("cfg%0d_DataB_r%0d", c, ra2), dataB[c], expData(c, ra2));
      check($sformatf("cfg%0d_Busy1_r%0d", c, ra1), {31'b0, busy1[c]}, {31'b0, expBusy(c, ra1)});
      check($sformatf("cfg%0d_Busy2_r%0d", c, ra2), {31'b0, busy2[c]}, {31'b0, expBusy(c, ra2)});
      check($sformatf("cfg%0d_AnyBusy", c), {31'b0, anyBusy[c]}, {31'b0, expAny(c)});
    end
  endtask

  task automatic applyStimulus(input logic iWe, input logic [AW-1:0] iWa, input logic [W-1:0] iDin,
                               input logic [AW-1:0] iRa1, input logic [AW-1:0] iRa2,
                               input logic iRes, input logic [AW-1:0] iRsa);
    we = iWe; wa = iWa; din = iDin; ra1 = iRa1; ra2 = iRa2; res = iRes; rsa = iRsa;
    #1;
    checkOutput();
  endtask

  // Model update at the active edge: write clears busy, then reserve sets it.
  task automatic tickClock();
    @(posedge clk);
    if (rstn) begin
      for (int c = 0; c < 2; c++) begin
        if (we && !(cfgZero[c] && wa == 0)) begin
          mRegs[c][wa] = din;
          mBusy[c][wa] = 1'b0;
        end
        if (res && !(cfgZero[c] && rsa == 0)) mBusy[c][rsa] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; we = 1'b0; wa = '0; din = '0; ra1 = '0; ra2 = '0; res = 1'b0; rsa = '0;
    clearModel();
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 5'd5, 32'hFFFF_0000, 5'd5, 5'd5, 1'b1, 5'd5);
    check("reset_DataA", dataA[0], 32'h0);
    check("reset_AnyBusy", {31'b0, anyBusy[0]}, 32'h0);
    tickClock();
    rstn = 1'b1;

    // Write then read back on both ports.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 1'b0, 5'd0);
    tickClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    check("r5_DataA", dataA[0], 32'hDEAD_BEEF);
    check("r5_DataB", dataB[0], 32'hDEAD_BEEF);
    tickClock();

    // Register zero ignores writes and reserves in the default instance.
    applyStimulus(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 5'd0);
    tickClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    check("zero_DataA", dataA[0], 32'h0);
    check("zero_Busy1", {31'b0, busy1[0]}, 32'h0);
    check("zero_AnyBusy", {31'b0, anyBusy[0]}, 32'h0);
    check("alt_r0_DataA", dataA[1], 32'h1234);
    tickClock();
    // Clear the alternate instance's r0 reservation.
    applyStimulus(1'b1, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0);
    tickClock();

    // Same-cycle forwarding versus old value.
    applyStimulus(1'b1, 5'd7, 32'h11, 5'd1, 5'd2, 1'b0, 5'd0);
    tickClock();
    applyStimulus(1'b1, 5'd7, 32'h22, 5'd7, 5'd3, 1'b0, 5'd0);
    check("byp_DataA", dataA[0], 32'h22);
    check("nobyp_DataA_old", dataA[1], 32'h11);
    tickClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
    check("nobyp_DataA_new", dataA[1], 32'h22);
    tickClock();

    // Reserve then write clears busy.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd3);
    tickClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
    check("res_Busy1", {31'b0, busy1[0]}, 32'h1);
    check("res_AnyBusy", {31'b0, anyBusy[0]}, 32'h1);
    tickClock();
    applyStimulus(1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b0, 5'd0);
    check("wr_Busy1_same", {31'b0, busy1[0]}, 32'h0);
    check("wr_Busy1_same_nobyp", {31'b0, busy1[1]}, 32'h1);
    tickClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 1'b0, 5'd0);
    check("wr_Busy1_after", {31'b0, busy1[0]}, 32'h0);
    check("wr_DataA_after", dataA[0], 32'h55);
    tickClock();

    // Reserve and write to the same register in one cycle: reserve wins.
    applyStimulus(1'b1, 5'd9, 32'hAA, 5'd1, 5'd2, 1'b1, 5'd9);
    tickClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    check("sameaddr_DataA", dataA[0], 32'hAA);
    check("sameaddr_Busy1", {31'b0, busy1[0]}, 32'h1);
    tickClock();

    // Fill the file with reserve of r4 mid-fill, then reset between edges.
    for (int i = 1; i < D; i++) begin
      applyStimulus(1'b1, i[AW-1:0], $urandom, 5'(i), 5'($urandom_range(0, D - 1)),
                    (i == 10), 5'd4);
      tickClock();
    end
    applyStimulus(1'b1, 5'd12, 32'hCAFE_F00D, 5'd4, 5'd12, 1'b1, 5'd6);
    check("prereset_AnyBusy", {31'b0, anyBusy[0]}, 32'h1);
    #2;
    rstn = 1'b0;
    clearModel();
    #1;
    checkOutput();
    check("midreset_DataB", dataB[0], 32'h0);
    check("midreset_AnyBusy", {31'b0, anyBusy[0]}, 32'h0);
    for (int i = 0; i < D; i += 7) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(D - 1 - i), 1'b0, 5'd0);
    end
    tickClock();
    rstn = 1'b1;

    // Randomised traffic, with addresses biased towards a small window.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] mask;
      mask = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'h07;
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom) & mask, $urandom,
                    5'($urandom) & mask, 5'($urandom) & mask,
                    $urandom_range(0, 2) == 0, 5'($urandom) & mask);
      tickClock();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
